occupancy_counter: RTL and testbench

OCCUPANCY_COUNTER -- requirements
Module: occupancy_counter

---
 rtl/occupancy_counter_pkg.sv | 48 ++++
 rtl/hex7seg.sv | 12 +
 rtl/occupancy_counter.sv | 138 +++++++++++++
 tb/tb_occupancy_counter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/occupancy_counter_pkg.sv
// Shared turnstile state codes, BCD counter payload and 7-segment patterns
// used by the occupancy counter and the turnstile controller.
package occupancy_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;

   typedef enum logic [2:0] {
      ST_I = 3'b000,
      ST_A = 3'b001,
      ST_B = 3'b010,
      ST_C = 3'b011,
      ST_D = 3'b100,
      ST_E = 3'b101
   } door_state_e;

   typedef struct packed {
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] units;
   } bcd2_t;

   // Active-low segments, bit 0 = segment a ... bit 6 = segment g.
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   function automatic logic [SEG_W-1:0] seg_pattern(input logic [DIGIT_W-1:0] digit);
      logic [SEG_W-1:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Codes 110 and 111 are not turnstile states and never form an event.
   function automatic logic is_valid_code(input logic [2:0] code);
      return code <= 3'(ST_E);
   endfunction

endpackage

// File: rtl/hex7seg.sv
// BCD digit to active-low 7-segment pattern, with a blanking override.
module hex7seg
   import occupancy_counter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               blank_i,
   output logic [SEG_W-1:0]   seg_o
);

   assign seg_o = blank_i ? SEG_BLANK : seg_pattern(digit_i);

endmodule

// File: rtl/occupancy_counter.sv
// Room occupancy and metal-alarm counter driven by turnstile state transitions,
// with BCD 7-segment display, full/empty indication and a sticky count error.
module occupancy_counter
   import occupancy_counter_pkg::*;
#(
   parameter int unsigned MAX_OCC = 20
) (
   input  logic [1:0]       KEY,
   input  logic [2:0]       door_state,
   input  logic [0:0]       SW,
   output logic [SEG_W-1:0] HEX0,
   output logic [SEG_W-1:0] HEX1,
   output logic [SEG_W-1:0] HEX2,
   output logic [SEG_W-1:0] HEX3,
   output logic [1:0]       LEDR,
   output logic [0:0]       LEDG
);

   localparam int unsigned BIN_W = 7;

   logic clk;
   logic rst_n;
   logic clr;

   logic [2:0] prev_q, prev_d;
   bcd2_t      occ_q,  occ_d;
   bcd2_t      alm_q,  alm_d;
   logic       err_q,  err_d;

   logic enter_c;
   logic exit_c;
   logic alarm_c;
   logic occ_max_c;
   logic occ_zero_c;
   logic [BIN_W-1:0] occ_bin_c;

   assign clk   = KEY[0];
   assign rst_n = KEY[1];
   assign clr   = SW[0];

   // Event decode from the previous and current turnstile codes.
   assign enter_c = (prev_q == ST_E) && (door_state == ST_I);
   assign exit_c  = (prev_q == ST_B) && (door_state == ST_I);
   assign alarm_c = is_valid_code(prev_q) && (prev_q != ST_D) && (door_state == ST_D);

   assign occ_max_c  = (occ_q.tens == 4'd9) && (occ_q.units == 4'd9);
   assign occ_zero_c = (occ_q.tens == 4'd0) && (occ_q.units == 4'd0);

   always_comb begin
      prev_d = door_state;
      occ_d  = occ_q;
      alm_d  = alm_q;
      err_d  = err_q;

      if (clr) begin
         occ_d = '0;
         alm_d = '0;
         err_d = 1'b0;
      end else begin
         if (enter_c) begin
            if (occ_max_c) begin
               err_d = 1'b1;
            end else if (occ_q.units == 4'd9) begin
               occ_d.units = 4'd0;
               occ_d.tens  = occ_q.tens + 4'd1;
            end else begin
               occ_d.units = occ_q.units + 4'd1;
            end
         end

         if (exit_c) begin
            if (occ_zero_c) begin
               err_d = 1'b1;
            end else if (occ_q.units == 4'd0) begin
               occ_d.units = 4'd9;
               occ_d.tens  = occ_q.tens - 4'd1;
            end else begin
               occ_d.units = occ_q.units - 4'd1;
            end
         end

         // Alarm count wraps silently at 99.
         if (alarm_c) begin
            if (alm_q.units == 4'd9) begin
               alm_d.units = 4'd0;
               alm_d.tens  = (alm_q.tens == 4'd9) ? 4'd0 : alm_q.tens + 4'd1;
            end else begin
               alm_d.units = alm_q.units + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 3'(ST_I);
         occ_q  <= '0;
         alm_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         occ_q  <= occ_d;
         alm_q  <= alm_d;
         err_q  <= err_d;
      end
   end

   assign occ_bin_c = BIN_W'(occ_q.tens) * BIN_W'(10) + BIN_W'(occ_q.units);

   assign LEDR[0] = occ_bin_c >= BIN_W'(MAX_OCC);
   assign LEDR[1] = err_q;
   assign LEDG[0] = occ_zero_c;

   hex7seg u_hex0 (
      .digit_i (occ_q.units),
      .blank_i (1'b0),
      .seg_o   (HEX0)
   );

   hex7seg u_hex1 (
      .digit_i (occ_q.tens),
      .blank_i (occ_q.tens == 4'd0),
      .seg_o   (HEX1)
   );

   hex7seg u_hex2 (
      .digit_i (alm_q.units),
      .blank_i (1'b0),
      .seg_o   (HEX2)
   );

   hex7seg u_hex3 (
      .digit_i (alm_q.tens),
      .blank_i (alm_q.tens == 4'd0),
      .seg_o   (HEX3)
   );

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench: integer occupancy/alarm model compared every cycle
// against two instances (default and MAX_OCC=3) plus directed literal checks.
module tb_occupancy_counter;

   localparam logic [2:0] C_I = 3'b000;
   localparam logic [2:0] C_A = 3'b001;
   localparam logic [2:0] C_B = 3'b010;
   localparam logic [2:0] C_D = 3'b100;
   localparam logic [2:0] C_E = 3'b101;

   localparam logic [6:0] P_BLANK = 7'b1111111;
   localparam logic [6:0] P_0     = 7'b1000000;
   localparam logic [6:0] P_1     = 7'b1111001;
   localparam logic [6:0] P_9     = 7'b0010000;

   logic       clk;
   logic       rst_n;
   logic [1:0] key;
   logic [2:0] ds;
   logic [0:0] sw;

   logic [6:0] hex0_a, hex1_a, hex2_a, hex3_a;
   logic [6:0] hex0_b, hex1_b, hex2_b, hex3_b;
   logic [1:0] ledr_a, ledr_b;
   logic [0:0] ledg_a, ledg_b;

   int checks = 0;
   int errors = 0;

   int m_occ;
   int m_alm;
   int m_prev;
   bit m_err;

   assign key = {rst_n, clk};

   occupancy_counter #(.MAX_OCC(20)) u_dut_a (
      .KEY(key), .door_state(ds), .SW(sw),
      .HEX0(hex0_a), .HEX1(hex1_a), .HEX2(hex2_a), .HEX3(hex3_a),
      .LEDR(ledr_a), .LEDG(ledg_a)
   );

   occupancy_counter #(.MAX_OCC(3)) u_dut_b (
      .KEY(key), .door_state(ds), .SW(sw),
      .HEX0(hex0_b), .HEX1(hex1_b), .HEX2(hex2_b), .HEX3(hex3_b),
      .LEDR(ledr_b), .LEDG(ledg_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input int d, input bit blank);
      logic [6:0] p;
      if (blank) return P_BLANK;
      case (d)
         0: p = 7'b1000000;
         1: p = 7'b1111001;
         2: p = 7'b0100100;
         3: p = 7'b0110000;
         4: p = 7'b0011001;
         5: p = 7'b0010010;
         6: p = 7'b0000010;
         7: p = 7'b1111000;
         8: p = 7'b0000000;
         default: p = 7'b0010000;
      endcase
      return p;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_occ = 0; m_alm = 0; m_prev = 0; m_err = 1'b0;
   endtask

   // Occupancy semantics straight from the event rules, on plain integers.
   task automatic model_edge(input int d, input bit s);
      if (s) begin
         m_occ = 0; m_alm = 0; m_err = 1'b0;
      end else begin
         if (m_prev == 5 && d == 0) begin
            if (m_occ == 99) m_err = 1'b1; else m_occ++;
         end
         if (m_prev == 2 && d == 0) begin
            if (m_occ == 0) m_err = 1'b1; else m_occ--;
         end
         if (m_prev <= 5 && m_prev != 4 && d == 4) m_alm = (m_alm + 1) % 100;
      end
      m_prev = d;
   endtask

   task automatic compare_all();
      chk("hex0_a", int'(hex0_a), int'(exp_seg(m_occ % 10, 1'b0)));
      chk("hex1_a", int'(hex1_a), int'(exp_seg(m_occ / 10, (m_occ / 10) == 0)));
      chk("hex2_a", int'(hex2_a), int'(exp_seg(m_alm % 10, 1'b0)));
      chk("hex3_a", int'(hex3_a), int'(exp_seg(m_alm / 10, (m_alm / 10) == 0)));
      chk("ledr_a", int'(ledr_a), {m_err, m_occ >= 20});
      chk("ledg_a", int'(ledg_a), int'(m_occ == 0));
      chk("hex0_b", int'(hex0_b), int'(exp_seg(m_occ % 10, 1'b0)));
      chk("ledr_b", int'(ledr_b), {m_err, m_occ >= 3});
   endtask

   always @(negedge clk) compare_all();

   task automatic step(input logic [2:0] d, input bit s);
      ds = d;
      sw = s;
      @(posedge clk);
      if (rst_n) model_edge(int'(d), s);
      #1;
   endtask

   task automatic enter_pass();
      step(C_E, 1'b0);
      step(C_I, 1'b0);
   endtask

   task automatic exit_pass();
      step(C_B, 1'b0);
      step(C_I, 1'b0);
   endtask

   // Reset pulse asserted and checked between clock edges, held over one edge.
   task automatic mid_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      int r;
      logic [2:0] d;
      rst_n = 1'b0;
      ds = C_I;
      sw = 1'b0;
      model_reset();
      #2;
      chk("rst_hex0", int'(hex0_a), int'(P_0));
      chk("rst_hex1", int'(hex1_a), int'(P_BLANK));
      chk("rst_hex2", int'(hex2_a), int'(P_0));
      chk("rst_hex3", int'(hex3_a), int'(P_BLANK));
      chk("rst_ledr", int'(ledr_a), 0);
      chk("rst_ledg", int'(ledg_a), 1);
      #10;
      rst_n = 1'b1;

      // Single entry I->A->E->I
      step(C_I, 1'b0); step(C_A, 1'b0); step(C_E, 1'b0); step(C_I, 1'b0);
      chk("entry1_model", m_occ, 1);
      chk("entry1_hex0", int'(hex0_a), int'(P_1));
      chk("entry1_hex1", int'(hex1_a), int'(P_BLANK));
      chk("entry1_ledg", int'(ledg_a), 0);

      // Carry 09 -> 10 then borrow back to 09
      for (int i = 0; i < 8; i++) enter_pass();
      chk("pre9_model", m_occ, 9);
      enter_pass();
      chk("carry_hex1", int'(hex1_a), int'(P_1));
      chk("carry_hex0", int'(hex0_a), int'(P_0));
      step(C_I, 1'b0); exit_pass();
      chk("borrow_model", m_occ, 9);
      chk("borrow_hex0", int'(hex0_a), int'(P_9));
      chk("borrow_hex1", int'(hex1_a), int'(P_BLANK));

      // Underflow error and its clear
      step(C_I, 1'b1);
      exit_pass();
      chk("uflow_err", int'(ledr_a[1]), 1);
      chk("uflow_model", m_occ, 0);
      step(C_I, 1'b1);
      chk("uflow_clr", int'(ledr_a[1]), 0);

      // Full threshold on the MAX_OCC=3 instance
      for (int i = 0; i < 3; i++) enter_pass();
      chk("full3_b", int'(ledr_b[0]), 1);
      chk("full3_a", int'(ledr_a[0]), 0);
      exit_pass();
      chk("full3_exit_b", int'(ledr_b[0]), 0);

      // Alarm, D->D not recounted, clear beats same-edge entry
      step(C_I, 1'b0); step(C_A, 1'b0); step(C_D, 1'b0); step(C_D, 1'b0); step(C_I, 1'b0);
      chk("alarm_model", m_alm, 1);
      chk("alarm_hex2", int'(hex2_a), int'(P_1));
      chk("alarm_occ", m_occ, 2);
      step(C_E, 1'b0); step(C_I, 1'b1);
      chk("clr_prio_hex0", int'(hex0_a), int'(P_0));
      chk("clr_prio_hex2", int'(hex2_a), int'(P_0));
      chk("clr_prio_ledg", int'(ledg_a), 1);

      // Reset mid-pass discards the pending entry
      enter_pass();
      step(C_E, 1'b0);
      mid_reset();
      chk("midrst_hex0", int'(hex0_a), int'(P_0));
      chk("midrst_ledg", int'(ledg_a), 1);
      step(C_I, 1'b0);
      chk("midrst_noentry", int'(ledg_a), 1);

      // Overflow at 99
      step(C_I, 1'b1);
      for (int i = 0; i < 99; i++) enter_pass();
      chk("ovf_pre_model", m_occ, 99);
      chk("ovf_pre_hex1", int'(hex1_a), int'(P_9));
      enter_pass();
      chk("ovf_err", int'(ledr_a[1]), 1);
      chk("ovf_hex0", int'(hex0_a), int'(P_9));
      exit_pass();
      chk("ovf_exit_model", m_occ, 98);

      // Alarm wrap 99 -> 00 without error
      step(C_I, 1'b1);
      for (int i = 0; i < 100; i++) begin
         step(C_I, 1'b0);
         step(C_D, 1'b0);
      end
      chk("awrap_model", m_alm, 0);
      chk("awrap_err", int'(ledr_a[1]), 0);
      chk("awrap_hex3", int'(hex3_a), int'(P_BLANK));

      // Randomized traffic with occasional clears and async resets
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 30)      d = C_I;
         else if (r < 50) d = C_E;
         else if (r < 68) d = C_B;
         else if (r < 78) d = C_D;
         else             d = 3'($urandom_range(0, 7));
         step(d, $urandom_range(0, 59) == 0);
         if ($urandom_range(0, 249) == 0) mid_reset();
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
